// File: rtl/wall_map_ctrl.sv
// Wall map owner: converts display pixel coordinates to tile lookups for the wall sprite ROM,
// and shares the single-port map RAM with game-logic writes and a whole-map clear sweep.
module wall_map_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MAP_W    = 64,
    parameter int MAP_H    = 48
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_valid,
    input  logic [9:0] i_pix_x,
    input  logic [9:0] i_pix_y,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [3:0] o_x,
    output logic [3:0] o_y,
    output logic       o_is_wall,
    output logic [1:0] o_sel,
    output logic       o_valid,
    output logic       o_hsync,
    output logic       o_vsync,
    input  logic       i_wr_req,
    input  logic [5:0] i_wr_col,
    input  logic [5:0] i_wr_row,
    input  logic [2:0] i_wr_data,
    output logic       o_wr_ack,
    input  logic       i_clr_req,
    output logic       o_busy
);
    localparam int          DEPTH     = MAP_W * MAP_H;
    localparam logic [11:0] LAST_ADDR = 12'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t      r_state, w_state_next;
    logic [11:0] r_clr_addr, w_clr_addr_next;
    logic        r_wr_ack, w_wr_ack_next;

    logic [2:0]  r_mem [0:DEPTH-1];
    logic [2:0]  r_rd_data;
    logic [11:0] w_ram_addr;
    logic        w_ram_we;
    logic [2:0]  w_ram_wdata;

    logic [5:0]  w_col, w_row;
    logic [3:0]  w_sub_x, w_sub_y;
    logic        w_in_range;
    logic        w_wr_slot, w_wr_ok;

    logic        r_s1_valid, r_s1_in_range, r_s1_hs, r_s1_vs;
    logic [3:0]  r_s1_x, r_s1_y;
    logic        r_s2_valid, r_s2_wall, r_s2_hs, r_s2_vs;
    logic [1:0]  r_s2_sel;
    logic [3:0]  r_s2_x, r_s2_y;

    // Tile index only matters in range; truncation to 6 bits is masked by w_in_range.
    assign w_col      = 6'(i_pix_x / 10'd10);
    assign w_row      = 6'(i_pix_y / 10'd10);
    assign w_sub_x    = 4'(i_pix_x % 10'd10);
    assign w_sub_y    = 4'(i_pix_y % 10'd10);
    assign w_in_range = (32'(i_pix_x) < H_ACTIVE) && (32'(i_pix_y) < V_ACTIVE);

    assign w_wr_slot = !i_pix_valid && (r_state == ST_IDLE) && !i_clr_req && i_wr_req;
    assign w_wr_ok   = (32'(i_wr_col) < MAP_W) && (32'(i_wr_row) < MAP_H);

    always_comb begin
        w_ram_addr  = {w_row, w_col};
        w_ram_we    = 1'b0;
        w_ram_wdata = 3'b000;
        if (!i_pix_valid) begin
            if (r_state == ST_CLEAR) begin
                w_ram_addr = r_clr_addr;
                w_ram_we   = 1'b1;
            end else if (w_wr_slot) begin
                w_ram_addr  = {i_wr_row, i_wr_col};
                w_ram_we    = w_wr_ok;
                w_ram_wdata = i_wr_data;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_wr_ack_next   = w_wr_slot;
        case (r_state)
            ST_IDLE: begin
                if (i_clr_req) begin
                    w_state_next    = ST_CLEAR;
                    w_clr_addr_next = '0;
                end
            end
            ST_CLEAR: begin
                if (!i_pix_valid) begin
                    if (r_clr_addr == LAST_ADDR) begin
                        w_state_next    = ST_IDLE;
                        w_clr_addr_next = '0;
                    end else begin
                        w_clr_addr_next = r_clr_addr + 12'd1;
                    end
                end
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    // Power-up lands in CLEAR since the map RAM itself has no reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= '0;
            r_wr_ack   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
            r_wr_ack   <= w_wr_ack_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end
        r_rd_data <= r_mem[w_ram_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_in_range <= 1'b0;
            r_s1_x        <= '0;
            r_s1_y        <= '0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s2_valid    <= 1'b0;
            r_s2_wall     <= 1'b0;
            r_s2_sel      <= '0;
            r_s2_x        <= '0;
            r_s2_y        <= '0;
            r_s2_hs       <= 1'b1;
            r_s2_vs       <= 1'b1;
        end else begin
            r_s1_valid    <= i_pix_valid;
            r_s1_in_range <= w_in_range;
            r_s1_x        <= w_sub_x;
            r_s1_y        <= w_sub_y;
            r_s1_hs       <= i_hsync;
            r_s1_vs       <= i_vsync;
            r_s2_valid    <= r_s1_valid;
            r_s2_wall     <= r_rd_data[2] & r_s1_valid & r_s1_in_range;
            r_s2_sel      <= (r_s1_valid && r_s1_in_range) ? r_rd_data[1:0] : 2'b00;
            r_s2_x        <= r_s1_x;
            r_s2_y        <= r_s1_y;
            r_s2_hs       <= r_s1_hs;
            r_s2_vs       <= r_s1_vs;
        end
    end

    assign o_x       = r_s2_x;
    assign o_y       = r_s2_y;
    assign o_is_wall = r_s2_wall;
    assign o_sel     = r_s2_sel;
    assign o_valid   = r_s2_valid;
    assign o_hsync   = r_s2_hs;
    assign o_vsync   = r_s2_vs;
    assign o_wr_ack  = r_wr_ack;
    assign o_busy    = (r_state == ST_CLEAR);

endmodule
